// File: rtl/out_stream_packer.sv
// Packs a narrow D_W-bit element stream into little-endian OUT_W-bit AXI-stream words.
// Optional frame-length checking is enabled by defining OUT_PACK_LEN_CHECK_EN.
module out_stream_packer #(
  parameter int D_W          = 8,
  parameter int OUT_W        = 32,
  parameter int MATRIXSIZE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [D_W-1:0]          in_tdata,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic                    in_tlast,
  output logic [OUT_W-1:0]        m_axis_tdata,
  output logic [OUT_W/8-1:0]      m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  input  logic [MATRIXSIZE_W-1:0] frame_len,
  output logic [MATRIXSIZE_W-1:0] frames_done,
  output logic                    len_err
);

  localparam int LANES  = OUT_W / D_W;
  localparam int KEEP_W = OUT_W / 8;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  logic [OUT_W-1:0]  acc_data;
  logic [IDX_W-1:0]  idx;
  logic              in_xfer;
  logic              out_xfer;
  logic              completing;
  logic [OUT_W-1:0]  acc_next;
  logic [OUT_W-1:0]  word_next;
  logic [KEEP_W-1:0] keep_next;

  assign in_tready  = !m_axis_tvalid || m_axis_tready;
  assign in_xfer    = in_tvalid && in_tready;
  assign out_xfer   = m_axis_tvalid && m_axis_tready;
  assign completing = (idx == LAST_LANE) || in_tlast;

  // Lanes above idx are always zero in the accumulator, so the outgoing word
  // is simply the accumulator with the current element dropped into lane idx.
  always_comb begin
    acc_next  = acc_data;
    word_next = acc_data;
    keep_next = '0;
    for (int l = 0; l < LANES; l++) begin
      if (IDX_W'(l) == idx) begin
        acc_next[l*D_W +: D_W]  = in_tdata;
        word_next[l*D_W +: D_W] = in_tdata;
      end
    end
    for (int b = 0; b < KEEP_W; b++) begin
      keep_next[b] = (b * 8) < ((int'(idx) + 1) * D_W);
    end
  end

  // A completing input load is placed after the output-drain clear so that a
  // simultaneous drain and reload yields back-to-back words.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_data      <= '0;
      idx           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frames_done   <= '0;
    end else begin
      if (out_xfer) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tlast) begin
          frames_done <= frames_done + MATRIXSIZE_W'(1);
        end
      end
      if (in_xfer) begin
        if (completing) begin
          acc_data      <= '0;
          idx           <= '0;
          m_axis_tdata  <= word_next;
          m_axis_tkeep  <= keep_next;
          m_axis_tlast  <= in_tlast;
          m_axis_tvalid <= 1'b1;
        end else begin
          acc_data <= acc_next;
          idx      <= idx + IDX_W'(1);
        end
      end
    end
  end

`ifdef OUT_PACK_LEN_CHECK_EN
  logic [MATRIXSIZE_W-1:0] elem_cnt;
  logic [MATRIXSIZE_W-1:0] cnt_plus1;

  assign cnt_plus1 = elem_cnt + MATRIXSIZE_W'(1);

  // Flags both a short frame (tlast early) and a long one (length reached without tlast).
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_cnt <= '0;
      len_err  <= 1'b0;
    end else if (in_xfer) begin
      elem_cnt <= in_tlast ? '0 : cnt_plus1;
      if (in_tlast ? (cnt_plus1 != frame_len) : (cnt_plus1 == frame_len)) begin
        len_err <= 1'b1;
      end
    end
  end
`else
  logic unused_frame_len;
  assign unused_frame_len = ^frame_len;
  assign len_err = 1'b0;
`endif

endmodule
